// File: rtl/fifo_frame_pkg.sv
// Shared types for the FIFO frame unpacker: parse states and length/byte widths.
package fifo_frame_pkg;
  localparam int LEN_WIDTH  = 16;
  localparam int BYTE_WIDTH = 8;

  typedef logic [LEN_WIDTH-1:0]  len_t;
  typedef logic [BYTE_WIDTH-1:0] byte_t;

  typedef enum logic [1:0] {
    LEN_HI  = 2'd0,
    LEN_LO  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_e;
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;
endmodule

// File: rtl/fifo_frame_unpacker.sv
// Pops length-prefixed frames from a first-word-fall-through byte FIFO and forwards
// legal payloads as a valid/ready byte stream; illegal frames are drained and counted.
module fifo_frame_unpacker
  import fifo_frame_pkg::*;
#(
  parameter int MAX_LEN   = 1518,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_data,
  output logic                 fifo_read_enable,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 busy
);
  localparam len_t MaxLenL = len_t'(MAX_LEN);

  // Output handshake: a byte transfers on a rising edge where out_valid=1 and out_ready=1;
  // while out_valid=1 and out_ready=0, out_data/out_sop/out_eop are held unchanged.
  state_e state_q;
  byte_t  len_hi_q;
  len_t   remaining_q;
  logic   first_q;
  logic   out_valid_q;
  byte_t  out_data_q;
  logic   out_sop_q;
  logic   out_eop_q;

  logic slot_free;
  logic pop;
  len_t len_w;
  logic last_w;
  logic frame_inc;
  logic drop_inc;

  assign slot_free = !out_valid_q || out_ready;
  assign len_w     = {len_hi_q, fifo_data};
  assign last_w    = (remaining_q == len_t'(1));

  always_comb begin
    pop = 1'b0;
    case (state_q)
      LEN_HI, LEN_LO, DROP: pop = !fifo_empty;
      PAYLOAD:              pop = !fifo_empty && slot_free;
      default:              pop = 1'b0;
    endcase
  end

  assign frame_inc = out_valid_q && out_ready && out_eop_q;
  assign drop_inc  = pop && (((state_q == LEN_LO) && (len_w == '0)) ||
                             ((state_q == DROP) && last_w));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LEN_HI;
      len_hi_q    <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      // A consumed byte empties the slot unless a payload pop below refills it.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        LEN_HI: begin
          if (pop) begin
            len_hi_q <= fifo_data;
            state_q  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (pop) begin
            if (len_w == '0) begin
              state_q <= LEN_HI;
            end else if (len_w > MaxLenL) begin
              remaining_q <= len_w;
              state_q     <= DROP;
            end else begin
              remaining_q <= len_w;
              first_q     <= 1'b1;
              state_q     <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= fifo_data;
            out_sop_q   <= first_q;
            out_eop_q   <= last_w;
            first_q     <= 1'b0;
            remaining_q <= remaining_q - len_t'(1);
            if (last_w) begin
              state_q <= LEN_HI;
            end
          end
        end
        DROP: begin
          if (pop) begin
            remaining_q <= remaining_q - len_t'(1);
            if (last_w) begin
              state_q <= LEN_HI;
            end
          end
        end
        default: state_q <= LEN_HI;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (frame_inc),
    .count   (frame_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (drop_inc),
    .count   (drop_count)
  );

  assign fifo_read_enable = pop;
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_sop          = out_sop_q;
  assign out_eop          = out_eop_q;
  assign busy             = (state_q != LEN_HI);
endmodule

// File: tb/tb_fifo_frame_unpacker.sv
// Bench for fifo_frame_unpacker: FWFT FIFO model, frame-level reference model, scenario tasks.
module tb_fifo_frame_unpacker;
  localparam int MAX_LEN = 1518;
  localparam int CNT_W   = 4;   // narrow counters so saturation is reachable quickly
  localparam int SAT     = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             fifo_empty = 1'b1;
  logic [7:0]       fifo_data = 8'h00;
  logic             fifo_read_enable;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_sop;
  logic             out_eop;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] drop_count;
  logic             busy;

  fifo_frame_unpacker #(.MAX_LEN(MAX_LEN), .CNT_WIDTH(CNT_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fifo_empty       (fifo_empty),
    .fifo_data        (fifo_data),
    .fifo_read_enable (fifo_read_enable),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_sop          (out_sop),
    .out_eop          (out_eop),
    .frame_count      (frame_count),
    .drop_count       (drop_count),
    .busy             (busy)
  );

  // ---------------- environment state ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] stim_q[$];
  logic [9:0] out_q[$];     // {sop, eop, data} as observed
  int         out_cyc_q[$];
  logic [9:0] exp_q[$];     // {sop, eop, data} as predicted
  int exp_frames, exp_drops;
  int ready_mode, hold_mode;
  int cyc;
  int empty_rd_viol, stab_viol, full_rd_viol;
  logic chk_slot;
  logic held;
  logic [9:0] held_val;
  logic [7:0] pop_tmp;
  int checks, failures;

  // FIFO pop + output monitor, sampled with pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (reset_n) begin
      if (fifo_read_enable && fifo_empty) empty_rd_viol++;
      if (chk_slot && out_valid && !out_ready && fifo_read_enable) full_rd_viol++;
      if (fifo_read_enable && !fifo_empty && fifo_q.size() > 0) pop_tmp = fifo_q.pop_front();
      if (held && out_valid && ({out_sop, out_eop, out_data} !== held_val)) stab_viol++;
      held     = out_valid && !out_ready;
      held_val = {out_sop, out_eop, out_data};
      if (out_valid && out_ready) begin
        out_q.push_back({out_sop, out_eop, out_data});
        out_cyc_q.push_back(cyc);
      end
    end else begin
      held = 1'b0;
    end
  end

  // Drive FIFO head and downstream ready away from the active edge.
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 3) == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    fifo_empty = ((hold_mode != 0) && ($urandom_range(0, 3) == 0)) || (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // ---------------- reference model ----------------
  // Walks the byte stream frame by frame: header, then forward, drop or skip.
  task automatic model_stream();
    int i;
    int len;
    i = 0;
    while (i + 1 < stim_q.size()) begin
      len = {stim_q[i], stim_q[i+1]};
      i = i + 2;
      if (len == 0) begin
        exp_drops++;
      end else if (len > MAX_LEN) begin
        exp_drops++;
        i = i + len;
      end else begin
        for (int k = 0; k < len; k++) exp_q.push_back({k == 0, k == len - 1, stim_q[i+k]});
        exp_frames++;
        i = i + len;
      end
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Index of first disagreement between observed and predicted streams, -1 if identical.
  function automatic int stream_diff();
    int n;
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) return i;
    if (out_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_env();
    fifo_q.delete();
    out_q.delete();
    out_cyc_q.delete();
    exp_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    empty_rd_viol = 0;
    stab_viol = 0;
    full_rd_viol = 0;
    chk_slot = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_env();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic feed_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) fifo_q.push_back(stim_q[i]);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (fifo_q.size() == 0 && !busy && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    clear_env();
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_sop, out_eop, busy, fifo_read_enable} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b exp 0", {out_valid, out_data, out_sop, out_eop, busy, fifo_read_enable});
    end
    checks++;
    if (frame_count !== '0 || drop_count !== '0) begin
      failures++;
      $display("FAIL reset_counters: got frames=%0d drops=%0d exp 0/0", frame_count, drop_count);
    end
    do_reset();
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    ready_mode = 0; hold_mode = 0;
    stim_q = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    model_stream();
    feed_range(0, stim_q.size());
    wait_idle(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: got busy=%0d exp idle", busy); end
    checks++;
    if (stream_diff() != -1) begin
      failures++;
      $display("FAIL basic_stream: got %0d items exp %0d, first diff %0d", out_q.size(), exp_q.size(), stream_diff());
    end
    checks++;
    if (out_cyc_q.size() != 3 || (out_cyc_q[2] - out_cyc_q[0]) != 2) begin
      failures++;
      $display("FAIL basic_back_to_back: got %0d beats, exp 3 on consecutive cycles", out_cyc_q.size());
    end
    checks++;
    if (frame_count !== CNT_W'(sat(exp_frames)) || drop_count !== CNT_W'(sat(exp_drops))) begin
      failures++;
      $display("FAIL basic_counts: got %0d/%0d exp %0d/%0d", frame_count, drop_count, sat(exp_frames), sat(exp_drops));
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy: got %0d exp 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    ready_mode = 1; hold_mode = 0; chk_slot = 1'b1;
    stim_q = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    model_stream();
    feed_range(0, stim_q.size());
    wait_idle(200, ok);
    checks++;
    if (!ok || stream_diff() != -1) begin
      failures++;
      $display("FAIL bp_stream: got %0d items exp %0d (idle=%0d)", out_q.size(), exp_q.size(), ok);
    end
    checks++;
    if (stab_viol != 0) begin failures++; $display("FAIL bp_stable: got %0d changes exp 0", stab_viol); end
    checks++;
    if (full_rd_viol != 0) begin failures++; $display("FAIL bp_slot_full_read: got %0d exp 0", full_rd_viol); end
    checks++;
    if (frame_count !== CNT_W'(1)) begin failures++; $display("FAIL bp_frames: got %0d exp 1", frame_count); end
    chk_slot = 1'b0;
  endtask

  task automatic test_zero_len();
    bit ok;
    do_reset();
    ready_mode = 0; hold_mode = 0;
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h5A};
    model_stream();
    feed_range(0, stim_q.size());
    wait_idle(200, ok);
    checks++;
    if (!ok || stream_diff() != -1) begin
      failures++;
      $display("FAIL zero_stream: got %0d items exp %0d (idle=%0d)", out_q.size(), exp_q.size(), ok);
    end
    checks++;
    if (drop_count !== CNT_W'(1) || frame_count !== CNT_W'(1)) begin
      failures++;
      $display("FAIL zero_counts: got drops=%0d frames=%0d exp 1/1", drop_count, frame_count);
    end
  endtask

  task automatic test_drop_long();
    bit ok;
    do_reset();
    ready_mode = 0; hold_mode = 0;
    stim_q.delete();
    stim_q.push_back(8'h05); stim_q.push_back(8'hF0);
    for (int i = 0; i < 1520; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    stim_q.push_back(8'h00); stim_q.push_back(8'h02); stim_q.push_back(8'h11); stim_q.push_back(8'h22);
    model_stream();
    feed_range(0, stim_q.size());
    wait_idle(5000, ok);
    checks++;
    if (!ok || stream_diff() != -1) begin
      failures++;
      $display("FAIL drop_stream: got %0d items exp %0d (idle=%0d)", out_q.size(), exp_q.size(), ok);
    end
    checks++;
    if (drop_count !== CNT_W'(1) || frame_count !== CNT_W'(1)) begin
      failures++;
      $display("FAIL drop_counts: got drops=%0d frames=%0d exp 1/1", drop_count, frame_count);
    end
  endtask

  task automatic test_len_boundary();
    bit ok;
    do_reset();
    ready_mode = 2; hold_mode = 1;
    stim_q.delete();
    stim_q.push_back(8'h05); stim_q.push_back(8'hEE);          // exactly MAX_LEN: forwarded
    for (int i = 0; i < 1518; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    stim_q.push_back(8'h05); stim_q.push_back(8'hEF);          // MAX_LEN+1: dropped
    for (int i = 0; i < 1519; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    stim_q.push_back(8'h00); stim_q.push_back(8'h01); stim_q.push_back(8'h3C);
    model_stream();
    feed_range(0, stim_q.size());
    wait_idle(30000, ok);
    checks++;
    if (!ok || stream_diff() != -1) begin
      failures++;
      $display("FAIL boundary_stream: got %0d items exp %0d (idle=%0d)", out_q.size(), exp_q.size(), ok);
    end
    checks++;
    if (drop_count !== CNT_W'(1) || frame_count !== CNT_W'(2)) begin
      failures++;
      $display("FAIL boundary_counts: got drops=%0d frames=%0d exp 1/2", drop_count, frame_count);
    end
    hold_mode = 0;
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    ready_mode = 0; hold_mode = 0;
    stim_q = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    model_stream();
    feed_range(0, 4);
    for (int i = 0; i < 50 && out_q.size() < 2; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (out_q.size() != 2 || busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold: got items=%0d busy=%0d valid=%0d exp 2/1/0", out_q.size(), busy, out_valid);
    end
    feed_range(4, 6);
    wait_idle(200, ok);
    checks++;
    if (!ok || stream_diff() != -1) begin
      failures++;
      $display("FAIL stall_stream: got %0d items exp %0d (idle=%0d)", out_q.size(), exp_q.size(), ok);
    end
    checks++;
    if (empty_rd_viol != 0) begin failures++; $display("FAIL stall_read_empty: got %0d exp 0", empty_rd_viol); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    ready_mode = 0; hold_mode = 0;
    stim_q = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    feed_range(0, stim_q.size());
    for (int i = 0; i < 50 && out_q.size() < 1; i++) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_sop, out_eop, busy} !== 12'd0 || frame_count !== '0) begin
      failures++;
      $display("FAIL reset_mid_clear: got %b frames=%0d exp 0", {out_valid, out_data, out_sop, out_eop, busy}, frame_count);
    end
    clear_env();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stim_q = '{8'h00, 8'h01, 8'h77};
    model_stream();
    feed_range(0, stim_q.size());
    wait_idle(200, ok);
    checks++;
    if (!ok || stream_diff() != -1 || frame_count !== CNT_W'(1)) begin
      failures++;
      $display("FAIL reset_mid_next: got items=%0d frames=%0d exp %0d/1", out_q.size(), frame_count, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] len;
    do_reset();
    ready_mode = 2; hold_mode = 1;
    stim_q.delete();
    for (int f = 0; f < 24; f++) begin
      len = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
      stim_q.push_back(len[15:8]);
      stim_q.push_back(len[7:0]);
      for (int b = 0; b < int'(len); b++) stim_q.push_back(8'($urandom_range(0, 255)));
    end
    model_stream();
    feed_range(0, stim_q.size());
    wait_idle(5000, ok);
    checks++;
    if (!ok || stream_diff() != -1) begin
      failures++;
      $display("FAIL random_stream: got %0d items exp %0d (idle=%0d)", out_q.size(), exp_q.size(), ok);
    end
    checks++;
    if (frame_count !== CNT_W'(sat(exp_frames)) || drop_count !== CNT_W'(sat(exp_drops))) begin
      failures++;
      $display("FAIL random_counts: got %0d/%0d exp %0d/%0d", frame_count, drop_count, sat(exp_frames), sat(exp_drops));
    end
    checks++;
    if (stab_viol != 0 || empty_rd_viol != 0) begin
      failures++;
      $display("FAIL random_protocol: got stab=%0d rd_empty=%0d exp 0/0", stab_viol, empty_rd_viol);
    end
    hold_mode = 0;
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    ready_mode = 0; hold_mode = 0;
    stim_q.delete();
    for (int i = 0; i < SAT + 3; i++) begin stim_q.push_back(8'h00); stim_q.push_back(8'h00); end
    for (int i = 0; i < SAT + 2; i++) begin
      stim_q.push_back(8'h00); stim_q.push_back(8'h01); stim_q.push_back(8'(i));
    end
    model_stream();
    feed_range(0, stim_q.size());
    wait_idle(1000, ok);
    checks++;
    if (!ok || stream_diff() != -1) begin
      failures++;
      $display("FAIL sat_stream: got %0d items exp %0d (idle=%0d)", out_q.size(), exp_q.size(), ok);
    end
    checks++;
    if (drop_count !== CNT_W'(SAT) || frame_count !== CNT_W'(SAT)) begin
      failures++;
      $display("FAIL sat_counts: got drops=%0d frames=%0d exp %0d/%0d", drop_count, frame_count, SAT, SAT);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0; failures = 0; cyc = 0;
    ready_mode = 0; hold_mode = 0;
    held = 1'b0;
    clear_env();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_drop_long();
    test_len_boundary();
    test_stall();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog: got no completion exp finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
